// File: rtl/shift_exec_unit_if.sv
// Handshake bundle for shift_exec_unit: operation request side and result side.
interface shift_exec_unit_if #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_data;
  logic [4:0]       in_shamt;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/shift_exec_unit.sv
// Two-stage 32-bit shifter (SLL/SRL/SRA, op 10 passes data) with valid/ready flow control.
// Define SHIFT_EXEC_SRA_EN to make op 11 an arithmetic right shift; otherwise it is SRL.
module shift_exec_unit #(
  parameter int TAG_W = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  shift_exec_unit_if.slave bus
);

  logic             s1_valid;
  logic [1:0]       s1_op;
  logic [31:0]      s1_data;
  logic [31:0]      s1_onehot;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_load;
  logic             in_fire;
  logic [31:0]      sll_res;
  logic [31:0]      srl_res;
  logic [31:0]      result;
`ifdef SHIFT_EXEC_SRA_EN
  logic [31:0]      fill_mask;
`endif

  assign s2_load     = !bus.out_valid || bus.out_ready;
  // in_ready is forced low while reset is held, even though S1 is already empty.
  assign bus.in_ready = rst_n && (!s1_valid || s2_load);
  assign in_fire      = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_op     <= 2'b00;
      s1_data   <= 32'h0;
      s1_onehot <= 32'h0;
      s1_tag    <= '0;
    end else begin
      if (flush)
        s1_valid <= 1'b0;
      else if (bus.in_ready)
        s1_valid <= bus.in_valid;
      if (in_fire) begin
        s1_op     <= bus.in_op;
        s1_data   <= bus.in_data;
        s1_onehot <= 32'h1 << bus.in_shamt;
        s1_tag    <= bus.in_tag;
      end
    end
  end

  // The one-hot shamt selects exactly one constant-distance shift term.
  always_comb begin
    sll_res = 32'h0;
    srl_res = 32'h0;
`ifdef SHIFT_EXEC_SRA_EN
    fill_mask = 32'h0;
`endif
    for (int i = 0; i < 32; i++) begin
      if (s1_onehot[i]) begin
        sll_res = sll_res | (s1_data << i);
        srl_res = srl_res | (s1_data >> i);
`ifdef SHIFT_EXEC_SRA_EN
        fill_mask = fill_mask | ~(32'hFFFF_FFFF >> i);
`endif
      end
    end
  end

  always_comb begin
    result = s1_data;
    case (s1_op)
      2'b00: result = sll_res;
      2'b01: result = srl_res;
`ifdef SHIFT_EXEC_SRA_EN
      2'b11: result = srl_res | (s1_data[31] ? fill_mask : 32'h0);
`else
      2'b11: result = srl_res;
`endif
      default: result = s1_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= 32'h0;
      bus.out_tag   <= '0;
    end else begin
      if (flush)
        bus.out_valid <= 1'b0;
      else if (s2_load)
        bus.out_valid <= s1_valid;
      if (s2_load && s1_valid) begin
        bus.out_data <= result;
        bus.out_tag  <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_shift_exec_unit.sv
// Directed-vector bench for shift_exec_unit: sweep, single ops, backpressure, flush, reset.
module tb_shift_exec_unit;

  logic clk;
  logic rst_n;
  logic flush;
  int   n_cmp;
  int   n_err;

`ifdef SHIFT_EXEC_SRA_EN
  localparam logic [31:0] SRA_EXP_A = 32'hF800_0000;
  localparam logic [31:0] SRA_EXP_B = 32'hFFF0_0000;
`else
  localparam logic [31:0] SRA_EXP_A = 32'h0800_0000;
  localparam logic [31:0] SRA_EXP_B = 32'h00F0_0000;
`endif

  shift_exec_unit_if #(.TAG_W(5)) bus ();

  shift_exec_unit #(.TAG_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_op(input logic [1:0] op, input logic [31:0] data,
                          input logic [4:0] shamt, input logic [4:0] tag);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_data  = data;
    bus.in_shamt = shamt;
    bus.in_tag   = tag;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %0b want 0", bus.out_valid); end
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %0b want 0", bus.in_ready); end
    n_cmp++;
    if (bus.out_data !== 32'h0) begin n_err++; $display("FAIL rst_out_data got %h want 0", bus.out_data); end
    n_cmp++;
    if (bus.out_tag !== 5'd0) begin n_err++; $display("FAIL rst_out_tag got %0d want 0", bus.out_tag); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready got %0b want 1", bus.in_ready); end
  endtask

  task automatic test_sweep();
    logic [31:0] exp_q [0:63];
    logic [4:0]  tagv;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 67; c++) begin
      @(negedge clk);
      if (c >= 2 && c < 66) begin
        tagv = 5'(c - 2);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== exp_q[c-2] || bus.out_tag !== tagv) begin
          n_err++;
          $display("FAIL sweep_%0d got v=%0b d=%h t=%0d want v=1 d=%h t=%0d",
                   c - 2, bus.out_valid, bus.out_data, bus.out_tag, exp_q[c-2], tagv);
        end
      end
      if (c == 66) begin
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL sweep_drain got %0b want 0", bus.out_valid); end
      end
      if (c < 64) begin
        if (c < 32) begin
          exp_q[c] = 32'hFFFF_FFFF << c;
          drive_op(2'b00, 32'hFFFF_FFFF, 5'(c), 5'(c));
        end else begin
          exp_q[c] = 32'hFFFF_FFFF >> (c - 32);
          drive_op(2'b01, 32'hFFFF_FFFF, 5'(c - 32), 5'(c));
        end
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL sweep_in_ready_%0d got 0 want 1", c); end
      end else begin
        bus.in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_single_ops();
    logic [1:0]  t_op   [0:11];
    logic [31:0] t_data [0:11];
    logic [4:0]  t_sh   [0:11];
    logic [31:0] t_exp  [0:11];
    t_op   = '{2'b10, 2'b11, 2'b00, 2'b01, 2'b11, 2'b10,
               2'b00, 2'b01, 2'b11, 2'b00, 2'b01, 2'b11};
    t_data = '{32'h1234_5678, 32'h8000_0000, 32'hA5A5_0F0F, 32'hA5A5_0F0F,
               32'hA5A5_0F0F, 32'hA5A5_0F0F, 32'h0000_0001, 32'h8000_0000,
               32'h7FFF_FFFF, 32'h1234_5678, 32'h1234_5678, 32'hF000_0000};
    t_sh   = '{5'd7, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd31, 5'd31, 5'd4, 5'd4, 5'd8};
    t_exp  = '{32'h1234_5678, SRA_EXP_A, 32'hA5A5_0F0F, 32'hA5A5_0F0F,
               32'hA5A5_0F0F, 32'hA5A5_0F0F, 32'h8000_0000, 32'h0000_0001,
               32'h0000_0000, 32'h2345_6780, 32'h0123_4567, SRA_EXP_B};
    bus.out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      drive_op(t_op[k], t_data[k], t_sh[k], 5'(k + 20));
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== t_exp[k] || bus.out_tag !== 5'(k + 20)) begin
        n_err++;
        $display("FAIL single_%0d got v=%0b d=%h t=%0d want v=1 d=%h t=%0d",
                 k, bus.out_valid, bus.out_data, bus.out_tag, t_exp[k], k + 20);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [4:0]  exp_tag  [0:3];
    logic [31:0] exp_data [0:3];
    int idx;
    int got;
    exp_tag  = '{5'd1, 5'd2, 5'd3, 5'd4};
    exp_data = '{32'h22, 32'h44, 32'h88, 32'h110};
    idx = 0;
    got = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      bus.out_ready = (cyc >= 5);
      if (idx < 4) drive_op(2'b00, 32'h11, 5'(idx + 1), 5'(idx + 1));
      else         bus.in_valid = 1'b0;
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_%0d got 1 want 0", cyc); end
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_tag !== 5'd1 || bus.out_data !== 32'h22) begin
          n_err++;
          $display("FAIL bp_hold_%0d got v=%0b d=%h t=%0d want v=1 d=00000022 t=1",
                   cyc, bus.out_valid, bus.out_data, bus.out_tag);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (got >= 4) begin
          n_err++;
          $display("FAIL bp_extra got t=%0d want no result", bus.out_tag);
        end else if (bus.out_tag !== exp_tag[got] || bus.out_data !== exp_data[got]) begin
          n_err++;
          $display("FAIL bp_order_%0d got d=%h t=%0d want d=%h t=%0d",
                   got, bus.out_data, bus.out_tag, exp_data[got], exp_tag[got]);
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) idx++;
    end
    bus.in_valid = 1'b0;
    n_cmp++;
    if (got !== 4) begin n_err++; $display("FAIL bp_count got %0d want 4", got); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    @(negedge clk);
    drive_op(2'b00, 32'h5, 5'd0, 5'd10);
    @(negedge clk);
    drive_op(2'b00, 32'h6, 5'd0, 5'd11);
    @(negedge clk);
    drive_op(2'b00, 32'h7, 5'd0, 5'd12);
    flush = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL flush_full_in_ready got 1 want 0"); end
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid got 1 want 0"); end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL flush_after_in_ready got 0 want 1"); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_leak_%0d got t=%0d want none", c, bus.out_tag); end
    end
    // Input offered with flush while the unit is ready must still vanish.
    @(negedge clk);
    drive_op(2'b01, 32'h8, 5'd1, 5'd13);
    flush = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready got 0 want 1"); end
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_drop_%0d got t=%0d want none", c, bus.out_tag); end
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    @(negedge clk);
    drive_op(2'b00, 32'hDEAD_0000, 5'd0, 5'd5);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL rmid_pre_valid got 0 want 1"); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_out_valid got 1 want 0"); end
    n_cmp++;
    if (bus.out_data !== 32'h0) begin n_err++; $display("FAIL rmid_out_data got %h want 0", bus.out_data); end
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rmid_in_ready got 1 want 0"); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    drive_op(2'b00, 32'h1, 5'd31, 5'd7);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_early got 1 want 0"); end
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h8000_0000 || bus.out_tag !== 5'd7) begin
      n_err++;
      $display("FAIL rmid_result got v=%0b d=%h t=%0d want v=1 d=80000000 t=7",
               bus.out_valid, bus.out_data, bus.out_tag);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.in_data   = 32'h0;
    bus.in_shamt  = 5'd0;
    bus.in_tag    = 5'd0;
    bus.out_ready = 1'b1;
    test_reset();
    test_sweep();
    test_single_ops();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_exec_unit.md
SHIFT_EXEC_UNIT -- requirements
Module: shift_exec_unit

Interface
REQ-001 Parameter: TAG_W, default 5, width of the destination-register tag carried alongside each operation.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 flush  input  1  synchronous pipeline kill.
REQ-005 in_valid  input  1  upstream operation valid.
REQ-006 in_ready  output  1  unit can accept an operation this cycle.
REQ-007 in_op  input  2  operation select: 00 SLL, 01 SRL, 11 SRA, 10 reserved.
REQ-008 in_data  input  32  operand to be shifted.
REQ-009 in_shamt  input  5  shift amount, 0..31.
REQ-010 in_tag  input  TAG_W  opaque tag, returned unchanged with the result.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 out_data  output  32  shift result.
REQ-014 out_tag  output  TAG_W  tag of the result.

Function
REQ-015 The unit SHALL be a two-stage pipeline: S1 registers op/data/tag and a 32-bit one-hot decode of shamt; S2 computes the shift from the one-hot value and registers out_data/out_tag.
REQ-016 An input transfer SHALL occur when in_valid and in_ready are both high on a rising edge; an output transfer SHALL occur when out_valid and out_ready are both high.
REQ-017 With out_ready held high, out_valid SHALL assert exactly 2 cycles after the accepting edge, and throughput SHALL be 1 operation per cycle.
REQ-018 S2 SHALL load when S2 is empty or its output transfers that cycle; S1 SHALL load when S1 is empty or S1 moves into S2 that cycle.
REQ-019 in_ready SHALL be high when S1 is empty or S1 advances this cycle (combinational from out_ready), and SHALL be low during reset.
REQ-020 While out_valid is high and out_ready is low, out_data and out_tag SHALL hold stable, and no accepted operation SHALL be dropped or duplicated.
REQ-021 SLL SHALL yield in_data << shamt, SRL SHALL yield a zero-filled in_data >> shamt, and reserved op 10 SHALL yield in_data unchanged.
REQ-022 shamt 0 SHALL yield in_data unchanged for every op; shamt 31 SHALL leave at most one original bit in the result.
REQ-023 Results SHALL leave the unit in acceptance order, each with its own tag.
REQ-024 flush high SHALL clear both stage valid bits at the next edge; an input presented in the same cycle SHALL be discarded (flush wins), and in_ready SHALL still follow REQ-019.
REQ-025 A simultaneous input transfer and output transfer with both stages full SHALL advance the whole pipeline with no bubble.

Reset
REQ-026 While rst_n is low: out_valid = 0, S1 valid = 0, in_ready = 0, out_data = 32'h0, out_tag = 0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight operations immediately (asynchronously); after release, the first accepted operation SHALL appear 2 cycles later.

Configuration
REQ-028 Macro SHIFT_EXEC_SRA_EN: when defined, op 11 SHALL yield an arithmetic right shift (vacated bits filled with in_data[31]).
REQ-029 Without SHIFT_EXEC_SRA_EN, op 11 SHALL behave exactly as SRL, and no sign-fill logic SHALL be synthesized.

Verification
REQ-030 Sweep: in_data 32'hFFFF_FFFF, shamt 0..31, op SLL then SRL, out_ready = 1 -> results match the << and >> references for every shamt, each 2 cycles after acceptance.
REQ-031 SRA: in_data 32'h8000_0000, shamt 4, op 11 -> 32'hF800_0000 with the macro defined, 32'h0800_0000 without it.
REQ-032 Backpressure: 4 back-to-back ops (tags 1..4), out_ready low for 5 cycles then high -> in_ready drops once both stages are full, out_data/out_tag stay stable, results arrive in order 1..4 with none lost.
REQ-033 Flush: two ops in flight plus a third presented with flush = 1 -> out_valid = 0 on the next cycle, and no result ever appears for those 3 tags.
REQ-034 Reset mid-stream: assert rst_n low while out_valid = 1 -> out_valid = 0 and out_data = 0 immediately; after release, op SLL on 32'h1 with shamt 31 -> 32'h8000_0000 after 2 cycles.
REQ-035 Reserved op 10 with in_data 32'h1234_5678 and shamt 7 -> out_data 32'h1234_5678.
